// File: rtl/dual_beam_thresh_servo.sv
// Threshold servo for dual_pueo_beam: counts both beams' triggers over a gate and steps each threshold toward a target rate.
// Latency: the threshold load sequence is 3 cycles; gate-to-gate cadence is period + 4 cycles.
// No backpressure: a started load sequence always completes, and dropping enable during a gate discards that gate.
module dual_beam_thresh_servo #(
   parameter int THRESH_BITS = 18,
   parameter int CNT_BITS    = 24,
   parameter int PERIOD_BITS = 32
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   enable_i,
   input  logic [1:0]             trigger_i,
   input  logic [PERIOD_BITS-1:0] period_i,
   input  logic [CNT_BITS-1:0]    target_i,
   input  logic [THRESH_BITS-1:0] step_i,
   input  logic [THRESH_BITS-1:0] thresh_init_i,
   output logic [THRESH_BITS-1:0] thresh_o,
   output logic [1:0]             thresh_ce_o,
   output logic                   update_o,
   output logic [CNT_BITS-1:0]    count_a_o,
   output logic [CNT_BITS-1:0]    count_b_o,
   output logic                   count_valid_o,
   output logic                   busy_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_A, S_LOAD_B, S_UPDATE, S_COUNT, S_CALC
   } state_t;

   state_t                 state_q, state_d;
   logic [THRESH_BITS-1:0] thr_a_q, thr_b_q, thr_a_d, thr_b_d;
   logic [CNT_BITS-1:0]    cnt_a_q, cnt_b_q, cnt_a_inc, cnt_b_inc;
   logic [PERIOD_BITS-1:0] gate_q, period_q;
   logic                   gate_last, gate_done;
   logic [THRESH_BITS-1:0] thresh_d;
   logic [1:0]             ce_d;
   logic                   upd_d;

   // One servo step: move the threshold up when the beam fires too often, down when too rarely,
   // clamping at both rails via a guard bit.
   function automatic logic [THRESH_BITS-1:0] servo_step(
      input logic [THRESH_BITS-1:0] thr,
      input logic [CNT_BITS-1:0]    cnt,
      input logic [CNT_BITS-1:0]    target,
      input logic [THRESH_BITS-1:0] step
   );
      logic [THRESH_BITS:0] up;
      logic [THRESH_BITS:0] dn;
      up = {1'b0, thr} + {1'b0, step};
      dn = {1'b0, thr} - {1'b0, step};
      if (cnt > target)
         servo_step = up[THRESH_BITS] ? '1 : up[THRESH_BITS-1:0];
      else if (cnt < target)
         servo_step = dn[THRESH_BITS] ? '0 : dn[THRESH_BITS-1:0];
      else
         servo_step = thr;
   endfunction

   assign gate_last = (gate_q == period_q - PERIOD_BITS'(1));
   assign gate_done = (state_q == S_COUNT) && enable_i && gate_last;
   assign cnt_a_inc = (&cnt_a_q) ? cnt_a_q : cnt_a_q + CNT_BITS'(trigger_i[1]);
   assign cnt_b_inc = (&cnt_b_q) ? cnt_b_q : cnt_b_q + CNT_BITS'(trigger_i[0]);
   assign busy_o    = (state_q != S_IDLE);

   // Next-state logic; the load sequence runs to completion regardless of enable.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (enable_i) state_d = S_LOAD_A;
         S_LOAD_A: state_d = S_LOAD_B;
         S_LOAD_B: state_d = S_UPDATE;
         S_UPDATE: state_d = enable_i ? S_COUNT : S_IDLE;
         S_COUNT: begin
            if (!enable_i)      state_d = S_IDLE;
            else if (gate_last) state_d = S_CALC;
         end
         S_CALC:   state_d = S_LOAD_A;
         default:  state_d = S_IDLE;
      endcase
   end

   // Threshold datapath: seed on leaving IDLE, servo step in CALC.
   always_comb begin
      thr_a_d = thr_a_q;
      thr_b_d = thr_b_q;
      if (state_q == S_IDLE && enable_i) begin
         thr_a_d = thresh_init_i;
         thr_b_d = thresh_init_i;
      end else if (state_q == S_CALC) begin
         thr_a_d = servo_step(thr_a_q, cnt_a_q, target_i, step_i);
         thr_b_d = servo_step(thr_b_q, cnt_b_q, target_i, step_i);
      end
   end

   // Beam-side load outputs, decoded from the next state so they are registered during each load cycle.
   always_comb begin
      thresh_d = thresh_o;
      ce_d     = 2'b00;
      upd_d    = 1'b0;
      case (state_d)
         S_LOAD_A: begin
            thresh_d = thr_a_d;
            ce_d     = 2'b10;
         end
         S_LOAD_B: begin
            thresh_d = thr_b_q;
            ce_d     = 2'b01;
         end
         S_UPDATE: upd_d = 1'b1;
         default: ;
      endcase
   end

   // State, thresholds, gate counters and exported counts.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q       <= S_IDLE;
         thr_a_q       <= '0;
         thr_b_q       <= '0;
         cnt_a_q       <= '0;
         cnt_b_q       <= '0;
         gate_q        <= '0;
         period_q      <= '0;
         thresh_o      <= '0;
         thresh_ce_o   <= '0;
         update_o      <= 1'b0;
         count_a_o     <= '0;
         count_b_o     <= '0;
         count_valid_o <= 1'b0;
      end else begin
         state_q       <= state_d;
         thr_a_q       <= thr_a_d;
         thr_b_q       <= thr_b_d;
         thresh_o      <= thresh_d;
         thresh_ce_o   <= ce_d;
         update_o      <= upd_d;
         count_valid_o <= gate_done;
         if (state_q == S_UPDATE) begin
            gate_q   <= '0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            period_q <= (period_i == '0) ? PERIOD_BITS'(1) : period_i;
         end else if (state_q == S_COUNT) begin
            gate_q  <= gate_q + PERIOD_BITS'(1);
            cnt_a_q <= cnt_a_inc;
            cnt_b_q <= cnt_b_inc;
         end
         if (gate_done) begin
            count_a_o <= cnt_a_inc;
            count_b_o <= cnt_b_inc;
         end
      end
   end

endmodule

// File: tb/tb_dual_beam_thresh_servo.sv
// Bench for dual_beam_thresh_servo: table of servo scenarios scored against expected load/count queues,
// plus hand sequences for enable drops, a narrow-counter instance and reset mid-gate.
// Single stimulus process; outputs are sampled on the falling clock edge.
module tb_dual_beam_thresh_servo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [1:0]  trig;
   logic [31:0] period;
   logic [23:0] target;
   logic [17:0] step;
   logic [17:0] init;
   logic [17:0] thresh_o;
   logic [1:0]  thresh_ce_o;
   logic        update_o;
   logic [23:0] count_a_o, count_b_o;
   logic        count_valid_o, busy_o;

   logic        en4;
   logic [1:0]  trig4;
   logic [31:0] per4;
   logic [3:0]  tgt4;
   logic [17:0] step4, init4, thr4;
   logic [1:0]  ce4;
   logic        upd4, cv4, busy4;
   logic [3:0]  ca4, cb4;

   always #5 clk = ~clk;

   dual_beam_thresh_servo dut (
      .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .trigger_i(trig),
      .period_i(period), .target_i(target), .step_i(step), .thresh_init_i(init),
      .thresh_o(thresh_o), .thresh_ce_o(thresh_ce_o), .update_o(update_o),
      .count_a_o(count_a_o), .count_b_o(count_b_o), .count_valid_o(count_valid_o),
      .busy_o(busy_o)
   );

   dual_beam_thresh_servo #(.THRESH_BITS(18), .CNT_BITS(4), .PERIOD_BITS(32)) dut4 (
      .clk_i(clk), .rst_n_i(rst_n), .enable_i(en4), .trigger_i(trig4),
      .period_i(per4), .target_i(tgt4), .step_i(step4), .thresh_init_i(init4),
      .thresh_o(thr4), .thresh_ce_o(ce4), .update_o(upd4),
      .count_a_o(ca4), .count_b_o(cb4), .count_valid_o(cv4), .busy_o(busy4)
   );

   typedef struct {
      logic [17:0]      init;
      logic [31:0]      period;
      logic [23:0]      target;
      logic [17:0]      step;
      logic [1:0]       trig;
      int               gates;
      logic [23:0]      cnt_a;
      logic [23:0]      cnt_b;
      logic [2:0][17:0] thr_a;
      logic [2:0][17:0] thr_b;
   } vec_t;

   typedef struct { logic [17:0] a; logic [17:0] b; } ld_t;
   typedef struct { logic [23:0] a; logic [23:0] b; } cnt_t;

   vec_t  vecs[7];
   ld_t   ldq[$];
   cnt_t  cq[$];
   int    vq[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    phase = 0;
   int    loads_done = 0;
   logic [23:0] last_a = '0, last_b = '0;

   function automatic vec_t mk(input logic [17:0] i, input logic [31:0] p, input logic [23:0] t,
                               input logic [17:0] s, input logic [1:0] tr, input int g,
                               input logic [23:0] ca, input logic [23:0] cb,
                               input logic [17:0] a0, input logic [17:0] a1, input logic [17:0] a2,
                               input logic [17:0] b0, input logic [17:0] b1, input logic [17:0] b2);
      vec_t v;
      v.init = i; v.period = p; v.target = t; v.step = s; v.trig = tr; v.gates = g;
      v.cnt_a = ca; v.cnt_b = cb;
      v.thr_a[0] = a0; v.thr_a[1] = a1; v.thr_a[2] = a2;
      v.thr_b[0] = b0; v.thr_b[1] = b1; v.thr_b[2] = b2;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Scoreboard monitor for the main instance; called once per falling edge.
   task automatic mon();
      if (thresh_ce_o == 2'b10) begin
         check("loadA_order", phase, 0);
         check("loadA_upd", update_o, 0);
         if (ldq.size() == 0) flag("loadA_unexpected");
         else check("loadA_thr", thresh_o, ldq[0].a);
         phase = 1;
      end else if (thresh_ce_o == 2'b01) begin
         check("loadB_order", phase, 1);
         check("loadB_upd", update_o, 0);
         if (ldq.size() == 0) flag("loadB_unexpected");
         else check("loadB_thr", thresh_o, ldq[0].b);
         phase = 2;
      end else if (thresh_ce_o != 2'b00) begin
         flag("ce_illegal");
      end
      if (update_o) begin
         check("update_order", phase, 2);
         check("update_ce", thresh_ce_o, 0);
         if (ldq.size() == 0) flag("update_unexpected");
         else begin
            check("update_thr_hold", thresh_o, ldq[0].b);
            void'(ldq.pop_front());
         end
         loads_done++;
         phase = 0;
      end
      if (count_valid_o) begin
         vq.push_back(cyc);
         if (cq.size() == 0) flag("count_valid_unexpected");
         else begin
            check("count_a", count_a_o, cq[0].a);
            check("count_b", count_b_o, cq[0].b);
            last_a = cq[0].a;
            last_b = cq[0].b;
            void'(cq.pop_front());
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      mon();
   endtask

   task automatic wait_loads(input int need, input int budget);
      int n = 0;
      while (loads_done < need && n < budget) begin
         tick();
         n++;
      end
      if (loads_done < need) flag("load_timeout");
   endtask

   initial begin
      rst_n = 1'b0; enable = 1'b0; trig = 2'b00; period = 32'd0; target = '0; step = '0; init = '0;
      en4 = 1'b0; trig4 = 2'b00; per4 = 32'd0; tgt4 = '0; step4 = '0; init4 = '0;

      //       init      P    tgt  step trig g  cntA cntB  thrA[0..2]                  thrB[0..2]
      vecs[0] = mk(18'h0F000, 100, 50, 16, 2'b11, 2, 100, 100, 18'h0F010, 18'h0F020, 0, 18'h0F010, 18'h0F020, 0);
      vecs[1] = mk(18'd20,      8,  5, 16, 2'b00, 3,   0,   0, 18'd4, 18'd0, 18'd0, 18'd4, 18'd0, 18'd0);
      vecs[2] = mk(18'h3FFF8,   8,  5, 16, 2'b11, 2,   8,   8, 18'h3FFFF, 18'h3FFFF, 0, 18'h3FFFF, 18'h3FFFF, 0);
      vecs[3] = mk(18'd100,     0,  0,  1, 2'b11, 2,   1,   1, 18'd101, 18'd102, 0, 18'd101, 18'd102, 0);
      vecs[4] = mk(18'd100,    10, 10,  5, 2'b11, 2,  10,  10, 18'd100, 18'd100, 0, 18'd100, 18'd100, 0);
      vecs[5] = mk(18'd1000,   10,  5,  7, 2'b10, 2,  10,   0, 18'd1007, 18'd1014, 0, 18'd993, 18'd986, 0);
      vecs[6] = mk(18'h3FFF0,   6,  3, 32, 2'b01, 2,   0,   6, 18'h3FFD0, 18'h3FFB0, 0, 18'h3FFFF, 18'h3FFFF, 0);

      repeat (3) tick();
      check("rst_thresh", thresh_o, 0);
      check("rst_ce", thresh_ce_o, 0);
      check("rst_update", update_o, 0);
      check("rst_count_a", count_a_o, 0);
      check("rst_count_b", count_b_o, 0);
      check("rst_valid", count_valid_o, 0);
      check("rst_busy", busy_o, 0);
      rst_n = 1'b1;
      repeat (2) tick();

      for (int v = 0; v < 7; v++) begin
         int pe;
         ld_t  l;
         cnt_t c;
         pe = (vecs[v].period == 0) ? 1 : int'(vecs[v].period);
         init = vecs[v].init; period = vecs[v].period; target = vecs[v].target;
         step = vecs[v].step; trig = vecs[v].trig;
         l.a = vecs[v].init; l.b = vecs[v].init;
         ldq.push_back(l);
         for (int g = 0; g < vecs[v].gates; g++) begin
            l.a = vecs[v].thr_a[g]; l.b = vecs[v].thr_b[g];
            ldq.push_back(l);
            c.a = vecs[v].cnt_a; c.b = vecs[v].cnt_b;
            cq.push_back(c);
         end
         vq.delete();
         loads_done = 0;
         enable = 1'b1;
         wait_loads(vecs[v].gates + 1, (pe + 4) * (vecs[v].gates + 1) + 20);
         enable = 1'b0;
         tick();
         check("idle_after_vec", busy_o, 0);
         check("loads_consumed", ldq.size(), 0);
         check("counts_consumed", cq.size(), 0);
         if (vq.size() >= 2) check("gate_cadence", vq[1] - vq[0], pe + 4);
         else flag("gate_cadence_missing");
         ldq.delete(); cq.delete();
         repeat (2) tick();
      end

      // Enable dropped during LOAD_B: the update still fires, then the servo idles.
      begin
         ld_t l;
         int n = 0;
         init = 18'd777; period = 32'd20; trig = 2'b11;
         l.a = 18'd777; l.b = 18'd777;
         ldq.push_back(l);
         loads_done = 0;
         enable = 1'b1;
         while (thresh_ce_o != 2'b01 && n < 20) begin tick(); n++; end
         if (thresh_ce_o != 2'b01) flag("loadB_timeout");
         enable = 1'b0;
         wait_loads(1, 5);
         tick();
         check("loadB_drop_idle", busy_o, 0);
         repeat (30) tick();
         check("loadB_drop_cnt_b", count_b_o, last_b);
      end

      // Enable dropped mid-gate: counts discarded, no valid pulse, outputs retained.
      begin
         ld_t l;
         init = 18'd555; period = 32'd50; trig = 2'b11;
         l.a = 18'd555; l.b = 18'd555;
         ldq.push_back(l);
         loads_done = 0;
         enable = 1'b1;
         wait_loads(1, 10);
         repeat (3) tick();
         check("count_busy", busy_o, 1);
         enable = 1'b0;
         tick();
         check("count_drop_idle", busy_o, 0);
         repeat (60) tick();
         check("count_drop_cnt_a", count_a_o, last_a);
         check("count_drop_cnt_b", count_b_o, last_b);
         check("count_drop_thresh", thresh_o, 18'd555);
      end

      // Narrow counter instance: counts saturate at 15, equal-to-target leaves thresholds alone.
      begin
         int n = 0;
         init4 = 18'd500; per4 = 32'd40; tgt4 = 4'd15; step4 = 18'd9; trig4 = 2'b11;
         en4 = 1'b1;
         while (!cv4 && n < 100) begin tick(); n++; end
         if (!cv4) flag("cnt4_timeout");
         check("cnt4_a_sat", ca4, 15);
         check("cnt4_b_sat", cb4, 15);
         n = 0;
         while (ce4 != 2'b10 && n < 10) begin tick(); n++; end
         check("cnt4_loadA", thr4, 18'd500);
         tick();
         check("cnt4_loadB_ce", ce4, 2'b01);
         check("cnt4_loadB", thr4, 18'd500);
         en4 = 1'b0;
         tick();
         check("cnt4_update", upd4, 1);
         tick();
         check("cnt4_idle", busy4, 0);
      end

      // Asynchronous reset in the middle of a gate.
      begin
         ld_t l;
         init = 18'h0F000; period = 32'd50; trig = 2'b11;
         l.a = 18'h0F000; l.b = 18'h0F000;
         ldq.push_back(l);
         loads_done = 0;
         enable = 1'b1;
         wait_loads(1, 10);
         repeat (10) tick();
         rst_n = 1'b0;
         #1;
         check("arst_thresh", thresh_o, 0);
         check("arst_ce", thresh_ce_o, 0);
         check("arst_update", update_o, 0);
         check("arst_count_a", count_a_o, 0);
         check("arst_count_b", count_b_o, 0);
         check("arst_valid", count_valid_o, 0);
         check("arst_busy", busy_o, 0);
         ldq.delete(); cq.delete();
         phase = 0;
         enable = 1'b0;
         tick();
         rst_n = 1'b1;
         repeat (3) tick();
         check("arst_stays_idle", busy_o, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
